// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow valid/ready beats into one wide word with per-lane keep and last.
// Ports: clk/rst (sync, active-high); valid_s/ready_s/data_s/last_s narrow input stream;
// valid_m/ready_m/data_m/keep_m/last_m wide output stream (lane i = data_m[i*DATA_WIDTH +: DATA_WIDTH]).
// The accumulation register is the output register, so data_s never reaches data_m combinationally.
module stream_upsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = $clog2(RATIO) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_s,
  output logic                        ready_s,
  input  logic [DATA_WIDTH-1:0]       data_s,
  input  logic                        last_s,
  output logic                        valid_m,
  input  logic                        ready_m,
  output logic [DATA_WIDTH*RATIO-1:0] data_m,
  output logic [RATIO-1:0]            keep_m,
  output logic                        last_m
);
  logic [CNT_W-1:0] cnt;
  logic acc, drain, fin;
  logic [DATA_WIDTH*RATIO-1:0] nxt_data;
  logic [RATIO-1:0] nxt_keep;
  assign ready_s = !valid_m || ready_m;
  assign acc = valid_s && ready_s;
  assign drain = valid_m && ready_m;
  assign fin = last_s || cnt == CNT_W'(RATIO - 1);
  // A draining word is replaced by a freshly cleared one, so untouched lanes read 0.
  for (genvar l = 0; l < RATIO; l++) begin : g_lane
    assign nxt_data[l*DATA_WIDTH +: DATA_WIDTH] = cnt == CNT_W'(l) ? data_s :
                                                  drain ? '0 : data_m[l*DATA_WIDTH +: DATA_WIDTH];
    assign nxt_keep[l] = cnt == CNT_W'(l) || (!drain && keep_m[l]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m <= 1'b0;
      last_m  <= 1'b0;
      data_m  <= '0;
      keep_m  <= '0;
      cnt     <= '0;
    end else if (acc) begin
      data_m  <= nxt_data;
      keep_m  <= nxt_keep;
      valid_m <= fin;
      last_m  <= fin && last_s;
      cnt     <= fin ? '0 : cnt + CNT_W'(1);
    end else if (drain) begin
      valid_m <= 1'b0;
      last_m  <= 1'b0;
      data_m  <= '0;
      keep_m  <= '0;
    end
  end
endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: scoreboard bench for stream_upsizer (RATIO=4 and RATIO=1 instances).
module tb_stream_upsizer;
  logic clk = 1'b0;
  logic rst;
  logic valid_s, ready_s, last_s, valid_m, ready_m, last_m;
  logic [7:0] data_s;
  logic [31:0] data_m;
  logic [3:0] keep_m;
  logic valid_s1, ready_s1, last_s1, valid_m1, last_m1;
  logic [7:0] data_s1, data_m1;
  logic [0:0] keep_m1;
  logic rm_dir, rm_rand, rnd;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0] k;
    logic l;
  } word_t;
  word_t sb[$];
  word_t w;
  logic [31:0] md;
  logic [3:0] mk;
  int mn;

  always #5 clk = ~clk;
  assign ready_m = rnd ? rm_rand : rm_dir;

  stream_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst), .valid_s(valid_s), .ready_s(ready_s), .data_s(data_s), .last_s(last_s),
    .valid_m(valid_m), .ready_m(ready_m), .data_m(data_m), .keep_m(keep_m), .last_m(last_m)
  );

  stream_upsizer #(.DATA_WIDTH(8), .RATIO(1)) dut1 (
    .clk(clk), .rst(rst), .valid_s(valid_s1), .ready_s(ready_s1), .data_s(data_s1), .last_s(last_s1),
    .valid_m(valid_m1), .ready_m(1'b1), .data_m(data_m1), .keep_m(keep_m1), .last_m(last_m1)
  );

  always @(posedge clk) begin
    #1 rm_rand = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst && valid_m && ready_m) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL word: unexpected output data=%h keep=%b last=%b", data_m, keep_m, last_m);
      end else begin
        w = sb.pop_front();
        if ({data_m, keep_m, last_m} !== w) begin
          errors++;
          $display("FAIL word: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                   data_m, keep_m, last_m, w.d, w.k, w.l);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model(input logic [7:0] d, input logic l);
    md[mn*8 +: 8] = d;
    mk[mn] = 1'b1;
    if (mn == 3 || l) begin
      sb.push_back({md, mk, l});
      md = '0;
      mk = '0;
      mn = 0;
    end else mn++;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    valid_s = 1'b1;
    data_s = d;
    last_s = l;
    @(negedge clk);
    while (!ready_s && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!ready_s) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_s stuck at 0 for beat %h", d);
    end
    @(posedge clk);
    #1;
    if (t < 200) model(d, l);
  endtask

  initial begin
    rst = 1'b1; valid_s = 1'b0; data_s = '0; last_s = 1'b0;
    valid_s1 = 1'b0; data_s1 = '0; last_s1 = 1'b0;
    rm_dir = 1'b1; rnd = 1'b0; md = '0; mk = '0; mn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {valid_m, keep_m, last_m, data_m}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready_s, 1);
    @(posedge clk); #1;
    // throughput: four back-to-back beats, word valid one cycle after the last
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    valid_s = 1'b0;
    @(negedge clk);
    chk("full_word", {valid_m, data_m, keep_m, last_m}, {1'b1, 32'h44332211, 4'hf, 1'b0});
    @(posedge clk); #1;
    // short packet, then next packet starts at lane 0
    send(8'hA1, 0); send(8'hA2, 1);
    valid_s = 1'b0;
    @(negedge clk);
    chk("short_word", {valid_m, data_m, keep_m, last_m}, {1'b1, 32'h0000A2A1, 4'b0011, 1'b1});
    @(posedge clk); #1;
    send(8'hB1, 1);
    valid_s = 1'b0;
    @(posedge clk); #1;
    // backpressure with a full word pending and a new beat waiting
    rm_dir = 1'b0;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    valid_s = 1'b1; data_s = 8'h55; last_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready_s", ready_s, 0);
      chk("bp_hold", {valid_m, data_m, keep_m, last_m}, {1'b1, 32'h04030201, 4'hf, 1'b0});
    end
    @(posedge clk); #1 rm_dir = 1'b1;
    send(8'h55, 0);
    valid_s = 1'b0;
    @(negedge clk);
    chk("accept_on_drain", {valid_m, keep_m, data_m}, {1'b0, 4'b0001, 32'h00000055});
    @(posedge clk); #1;
    send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
    valid_s = 1'b0;
    @(posedge clk); #1;
    // reset mid-word discards the partial word
    send(8'hC1, 0); send(8'hC2, 0);
    valid_s = 1'b0; rst = 1'b1;
    md = '0; mk = '0; mn = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_word", {valid_m, keep_m}, '0);
    @(posedge clk); #1;
    send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 0);
    valid_s = 1'b0;
    @(negedge clk);
    chk("after_reset_word", {valid_m, data_m, keep_m}, {1'b1, 32'hD4D3D2D1, 4'hf});
    @(posedge clk); #1;
    // RATIO=1 pass-through
    valid_s1 = 1'b1; data_s1 = 8'h5A; last_s1 = 1'b1;
    @(negedge clk);
    chk("r1_ready", ready_s1, 1);
    @(posedge clk); #1 valid_s1 = 1'b0;
    @(negedge clk);
    chk("r1_word", {valid_m1, data_m1, keep_m1, last_m1}, {1'b1, 8'h5A, 1'b1, 1'b1});
    @(posedge clk); #1;
    // random streaming with toggling ready_m and valid_s gaps
    rnd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        valid_s = 1'b0;
        @(posedge clk); #1;
      end
      send(8'($urandom), i == 63 || $urandom_range(0, 4) == 0);
    end
    valid_s = 1'b0;
    rnd = 1'b0;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Packs RATIO consecutive narrow beats of a valid/ready stream into one wide beat.
- Sits directly downstream of the stream skid buffer and consumes its registered output.
- Feeds wide-datapath consumers such as a wide FIFO or a memory write port.
- Carries packet boundaries through `last`; a short final word is flagged with a per-lane keep mask.

Parameters:
- DATA_WIDTH, 8, width of one narrow input beat (one lane).
- RATIO, 4, lanes per output word; legal range 1..16.
- CNT_W, $clog2(RATIO)+1, lane counter width (derived; not overridden).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- valid_s  input  1  narrow beat valid
- ready_s  output  1  narrow beat accepted when valid_s && ready_s
- data_s  input  DATA_WIDTH  narrow beat data
- last_s  input  1  final narrow beat of a packet
- valid_m  output  1  wide word valid
- ready_m  input  1  downstream accepts wide word when valid_m && ready_m
- data_m  output  DATA_WIDTH*RATIO  wide word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- keep_m  output  RATIO  bit i set when lane i holds a valid beat
- last_m  output  1  wide word ends a packet

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - Reset values: valid_m=0, keep_m=0, last_m=0, data_m=0, lane counter=0.
  - ready_s=1 one cycle after rst deasserts.
  - rst mid-packet discards any partial word; no output is produced for it.
- Single accumulation register; it doubles as the output register. No combinational path from data_s to data_m.
- ready_s = !valid_m || ready_m, combinational. Sustained throughput is one narrow beat per cycle with no bubbles at word boundaries.
- Accept (valid_s && ready_s) with counter=n:
  - lane n <= data_s and keep bit n <= 1.
  - If n==RATIO-1 or last_s=1:
    - valid_m <= 1 next cycle, last_m <= last_s, counter <= 0.
  - Otherwise counter <= n+1.
- Lane order: first accepted beat of a word lands in lane 0 (LSBs).
- Drain (valid_m && ready_m):
  - With no accept in the same cycle: valid_m, keep_m and last_m clear; data lanes clear to 0.
  - With an accept in the same cycle: the old word leaves. The new beat writes lane 0 of a freshly cleared word; all other lanes become 0 and their keep bits 0.
- Short final word: lanes above the last filled lane read 0 and their keep bits are 0. keep_m is always a contiguous run of ones from bit 0.
- While valid_m=1 and ready_m=0, data_m, keep_m and last_m stay stable (AXI-stream rule).
- valid_s/data_s stalls (valid_s=0) mid-word hold the counter and lanes; valid_m stays 0.
- RATIO=1: registered pass-through with one cycle latency; keep_m=1; last_m follows last_s.
- Latency: the wide word is valid the cycle after its final narrow beat is accepted.
- Undefined input: valid_s dropping before acceptance is an upstream protocol error; no special handling.

Test Plan:
- Throughput: RATIO=4, DATA_WIDTH=8, beats 0x11,0x22,0x33,0x44 back-to-back, ready_m=1.
  - Required: one cycle after 0x44, valid_m=1, data_m=0x44332211, keep_m=4'b1111, last_m=0.
- Short packet: beats 0xA1,0xA2 with last_s on 0xA2.
  - Required: data_m=0x0000A2A1, keep_m=4'b0011, last_m=1.
  - Next packet's first beat lands in lane 0.
- Backpressure: hold ready_m=0 with a full word pending.
  - Required: ready_s=0, and data_m/keep_m/last_m are unchanged for 10 cycles.
  - On ready_m=1 in the same cycle as valid_s: the new beat is accepted and the counter becomes 1.
- Continuous streaming: 64 random beats with random last_s, valid_s and ready_m toggling.
  - Scoreboard: the unpacked wide stream equals the narrow stream in order, with packet boundaries preserved.
  - Required: no beat lost or duplicated.
- Reset mid-word: accept 2 beats, then assert rst for 1 cycle.
  - Required: valid_m=0 and keep_m=0.
  - The next 4 beats form a complete word starting at lane 0.
- Degenerate: RATIO=1, beat 0x5A with last_s=1.
  - Required: next cycle data_m=0x5A, keep_m=1, last_m=1.
